// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-save decoder.
// Holds the default operand width, the segment count, the resulting segment
// width, and constant functions that build signed min/max bit patterns.
package csa_pkg;

    localparam int CSA_WIDTH = 32;
    localparam int CSA_SEGS  = 4;
    localparam int CSA_SEG_W = CSA_WIDTH / CSA_SEGS;

    // Widest result the min/max helpers can describe; callers size-cast down.
    localparam int CSA_MAX_W = 128;

    // Largest signed value at width w: 0 followed by w-1 ones.
    function automatic logic [CSA_MAX_W-1:0] csa_smax(input int w);
        logic [CSA_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CSA_MAX_W; i++) begin
            r[i] = (i < w - 1);
        end
        return r;
    endfunction

    // Smallest signed value at width w: 1 followed by w-1 zeros.
    function automatic logic [CSA_MAX_W-1:0] csa_smin(input int w);
        logic [CSA_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CSA_MAX_W; i++) begin
            r[i] = (i == w - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_seg_stage.sv
// One carry-propagate segment of the decoder pipeline.
// Adds the operand slice [LO +: N] plus the carry handed over by the previous
// segment, then registers the whole token (operands, partial sum, carry-out)
// together with its valid bit. The stage loads whenever it is empty or the
// next stage is taking its current token, so bubbles collapse.
module csa_seg_stage
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int LO    = 0,
    parameter int N     = CSA_SEG_W
) (
    input  logic             i_clkp,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_nxt_ready,
    input  logic [WIDTH+1:0] i_a,
    input  logic [WIDTH+1:0] i_b,
    input  logic [WIDTH+1:0] i_sum,
    input  logic             i_cin,
    output logic             o_valid,
    output logic [WIDTH+1:0] o_a,
    output logic [WIDTH+1:0] o_b,
    output logic [WIDTH+1:0] o_sum,
    output logic             o_cout
);

    logic [N:0]       seg_d;
    logic [WIDTH+1:0] sum_d;
    logic             valid_q;
    logic [WIDTH+1:0] a_q;
    logic [WIDTH+1:0] b_q;
    logic [WIDTH+1:0] sum_q;
    logic             cout_q;

    assign o_ready = ~valid_q | i_nxt_ready;

    // Resolve this segment's slice and splice it into the partial sum.
    always_comb begin
        seg_d = {1'b0, i_a[LO +: N]} + {1'b0, i_b[LO +: N]} + {{N{1'b0}}, i_cin};
        sum_d = i_sum;
        sum_d[LO +: N] = seg_d[N-1:0];
    end

    // Token register: advance when empty or when the next stage drains us.
    always_ff @(posedge i_clkp or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (o_ready) begin
            valid_q <= i_valid;
            if (i_valid) begin
                a_q    <= i_a;
                b_q    <= i_b;
                sum_q  <= sum_d;
                cout_q <= seg_d[N];
            end
        end
    end

    assign o_valid = valid_q;
    assign o_a     = a_q;
    assign o_b     = b_q;
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;

endmodule

// File: rtl/csa_decoder.sv
// Carry-save to two's-complement decoder.
// Resolves V = signed(i_d) + 2*signed(i_c) in WIDTH+2 bits across SEGS
// pipelined segments with valid/ready flow control. o_ovf flags results
// outside the signed WIDTH range; o_sum wraps by default.
// Build option CSA_DECODER_SAT_EN: adds one output register that clamps
// o_sum to the signed min/max on overflow (latency SEGS+1 instead of SEGS).
module csa_decoder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SEGS  = CSA_SEGS
) (
    input  logic             i_clkp,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    localparam int SEG_W = WIDTH / SEGS;
    localparam int XW    = WIDTH + 2;

    logic [SEGS-1:0]         st_valid;
    logic [SEGS-1:0]         st_ready;
    logic [SEGS-1:0]         st_cout;
    logic [SEGS-1:0][XW-1:0] st_a;
    logic [SEGS-1:0][XW-1:0] st_b;
    logic [SEGS-1:0][XW-1:0] st_sum;
    logic                    last_nxt_ready;
    logic [XW-1:0]           a_in;
    logic [XW-1:0]           b_in;
    logic [XW-1:0]           last_sum;
    logic                    ovf_d;
    logic                    unused_tail;

    // Sign-extend the sum vector; the carry vector carries weight 2^(i+1).
    assign a_in = {{2{i_d[WIDTH-1]}}, i_d};
    assign b_in = {i_c[WIDTH-1], i_c, 1'b0};

    for (genvar k = 0; k < SEGS; k++) begin : g_seg
        // The last segment also resolves the two guard bits used for overflow.
        localparam int LO = k * SEG_W;
        localparam int N  = (k == SEGS - 1) ? SEG_W + 2 : SEG_W;

        logic          in_valid;
        logic          in_cin;
        logic          nxt_ready;
        logic [XW-1:0] in_a;
        logic [XW-1:0] in_b;
        logic [XW-1:0] in_sum;

        if (k == 0) begin : g_head
            assign in_valid = i_valid;
            assign in_a     = a_in;
            assign in_b     = b_in;
            assign in_sum   = '0;
            assign in_cin   = 1'b0;
        end else begin : g_body
            assign in_valid = st_valid[k-1];
            assign in_a     = st_a[k-1];
            assign in_b     = st_b[k-1];
            assign in_sum   = st_sum[k-1];
            assign in_cin   = st_cout[k-1];
        end

        if (k == SEGS - 1) begin : g_tail
            assign nxt_ready = last_nxt_ready;
        end else begin : g_mid
            assign nxt_ready = st_ready[k+1];
        end

        csa_seg_stage #(
            .WIDTH (WIDTH),
            .LO    (LO),
            .N     (N)
        ) u_stage (
            .i_clkp      (i_clkp),
            .i_rst       (i_rst),
            .i_valid     (in_valid),
            .o_ready     (st_ready[k]),
            .i_nxt_ready (nxt_ready),
            .i_a         (in_a),
            .i_b         (in_b),
            .i_sum       (in_sum),
            .i_cin       (in_cin),
            .o_valid     (st_valid[k]),
            .o_a         (st_a[k]),
            .o_b         (st_b[k]),
            .o_sum       (st_sum[k]),
            .o_cout      (st_cout[k])
        );
    end

    assign o_ready  = st_ready[0];
    assign last_sum = st_sum[SEGS-1];

    // In range iff the two guard bits match the WIDTH-bit sign bit.
    assign ovf_d = ~((&last_sum[XW-1:WIDTH-1]) | ~(|last_sum[XW-1:WIDTH-1]));

    // The final token's operands and carry-out are fully consumed already.
    assign unused_tail = ^{st_a[SEGS-1], st_b[SEGS-1], st_cout[SEGS-1]};

`ifdef CSA_DECODER_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(csa_smax(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(csa_smin(WIDTH));

    logic             sat_valid_q;
    logic [WIDTH-1:0] sat_sum_q;
    logic             sat_ovf_q;
    logic [WIDTH-1:0] sat_sum_d;

    assign last_nxt_ready = ~sat_valid_q | i_ready;

    // Clamp toward the sign of the true value when it overflowed.
    always_comb begin
        sat_sum_d = last_sum[WIDTH-1:0];
        if (ovf_d) begin
            sat_sum_d = last_sum[XW-1] ? SMIN : SMAX;
        end
    end

    // Saturating output register, same load rule as the segment stages.
    always_ff @(posedge i_clkp or posedge i_rst) begin
        if (i_rst) begin
            sat_valid_q <= 1'b0;
            sat_sum_q   <= '0;
            sat_ovf_q   <= 1'b0;
        end else if (last_nxt_ready) begin
            sat_valid_q <= st_valid[SEGS-1];
            if (st_valid[SEGS-1]) begin
                sat_sum_q <= sat_sum_d;
                sat_ovf_q <= ovf_d;
            end
        end
    end

    assign o_valid = sat_valid_q;
    assign o_sum   = sat_sum_q;
    assign o_ovf   = sat_ovf_q;
`else
    assign last_nxt_ready = i_ready;
    assign o_valid        = st_valid[SEGS-1];
    assign o_sum          = last_sum[WIDTH-1:0];
    assign o_ovf          = ovf_d;
`endif

endmodule

// File: tb/tb_csa_decoder.sv
// Directed bench for csa_decoder at WIDTH=32, SEGS=4.
// Covers reset values, single-token latency and results, overflow in both
// directions, range boundaries, a stalled 6-token stream, and reset with
// tokens in flight. Works for the default and the saturating build.
module tb_csa_decoder;

    localparam int W = 32;
    localparam int S = 4;
`ifdef CSA_DECODER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int LAT = S + (SAT ? 1 : 0);

    logic         i_clkp;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_d;
    logic [W-1:0] i_c;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_ovf;

    int checks = 0;
    int errors = 0;

    csa_decoder #(.WIDTH(W), .SEGS(S)) dut (
        .i_clkp  (i_clkp),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_d     (i_d),
        .i_c     (i_c),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf)
    );

    initial i_clkp = 1'b0;
    always #5 i_clkp = ~i_clkp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One token in, wait for it, check latency/result, confirm it drains.
    task automatic run_one(input string tag, input logic [W-1:0] d, input logic [W-1:0] c,
                           input logic [W-1:0] s_wrap, input logic [W-1:0] s_sat, input logic ovf);
        int cnt;
        @(negedge i_clkp);
        i_valid = 1'b1;
        i_d     = d;
        i_c     = c;
        i_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(o_ready), 64'(1));
        @(negedge i_clkp);
        i_valid = 1'b0;
        cnt = 1;
        while (!o_valid && cnt < 20) begin
            @(negedge i_clkp);
            cnt++;
        end
        chk({tag, "_lat"}, 64'(cnt), 64'(LAT));
        chk({tag, "_sum"}, 64'(o_sum), 64'(SAT ? s_sat : s_wrap));
        chk({tag, "_ovf"}, 64'(o_ovf), 64'(ovf));
        @(negedge i_clkp);
        chk({tag, "_drain"}, 64'(o_valid), 64'(0));
    endtask

    logic [W-1:0] vd   [6];
    logic [W-1:0] vc   [6];
    logic [W-1:0] ewrp [6];
    logic [W-1:0] esat [6];
    logic         eovf [6];

    initial begin
        int           sent;
        int           rcv;
        int           cyc;
        int           wcnt;
        bit           stalled;
        bit           saw_full;
        bit           stale;
        logic [W-1:0] hsum;
        logic         hovf;

        vd[0] = 32'h0000_0010; vc[0] = 32'h0000_0003; ewrp[0] = 32'h0000_0016; esat[0] = 32'h0000_0016; eovf[0] = 1'b0;
        vd[1] = 32'hFFFF_FFFF; vc[1] = 32'hFFFF_FFFF; ewrp[1] = 32'hFFFF_FFFD; esat[1] = 32'hFFFF_FFFD; eovf[1] = 1'b0;
        vd[2] = 32'h7FFF_FFFF; vc[2] = 32'h4000_0000; ewrp[2] = 32'hFFFF_FFFF; esat[2] = 32'h7FFF_FFFF; eovf[2] = 1'b1;
        vd[3] = 32'h1234_5678; vc[3] = 32'h0000_1000; ewrp[3] = 32'h1234_7678; esat[3] = 32'h1234_7678; eovf[3] = 1'b0;
        vd[4] = 32'h8000_0000; vc[4] = 32'hC000_0000; ewrp[4] = 32'h0000_0000; esat[4] = 32'h8000_0000; eovf[4] = 1'b1;
        vd[5] = 32'h0000_FFFF; vc[5] = 32'h0000_8000; ewrp[5] = 32'h0001_FFFF; esat[5] = 32'h0001_FFFF; eovf[5] = 1'b0;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_d     = '0;
        i_c     = '0;

        #2;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_sum",   64'(o_sum),   64'(0));
        chk("rst_ovf",   64'(o_ovf),   64'(0));
        @(negedge i_clkp);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 64'(o_ready), 64'(1));

        run_one("basic",   32'h0000_00FF, 32'h0000_0001, 32'h0000_0101, 32'h0000_0101, 1'b0);
        run_one("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0);
        run_one("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
        run_one("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 32'h8000_0000, 1'b1);
        run_one("max_ok",  32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_one("min_ok",  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Six back-to-back tokens, downstream stalled in cycles 3..7.
        sent     = 0;
        rcv      = 0;
        stalled  = 1'b0;
        saw_full = 1'b0;
        hsum     = '0;
        hovf     = 1'b0;
        for (cyc = 0; rcv < 6 && cyc < 60; cyc++) begin
            @(negedge i_clkp);
            i_ready = !(cyc >= 3 && cyc <= 7);
            i_valid = (sent < 6);
            if (sent < 6) begin
                i_d = vd[sent];
                i_c = vc[sent];
            end
            #1;
            if (stalled) begin
                chk("bp_hold_valid", 64'(o_valid), 64'(1));
                chk("bp_hold_sum",   64'(o_sum),   64'(hsum));
                chk("bp_hold_ovf",   64'(o_ovf),   64'(hovf));
            end
            if (!o_ready) saw_full = 1'b1;
            if (i_valid && o_ready) sent++;
            if (o_valid && i_ready) begin
                chk($sformatf("bp_sum%0d", rcv), 64'(o_sum), 64'(SAT ? esat[rcv] : ewrp[rcv]));
                chk($sformatf("bp_ovf%0d", rcv), 64'(o_ovf), 64'(eovf[rcv]));
                rcv++;
            end
            stalled = o_valid && !i_ready;
            hsum    = o_sum;
            hovf    = o_ovf;
        end
        i_valid = 1'b0;
        chk("bp_sent",   64'(sent),     64'(6));
        chk("bp_count",  64'(rcv),      64'(6));
        chk("bp_full",   64'(saw_full), 64'(1));
        chk("bp_cycles", 64'(cyc),      64'(14));

        // Three tokens held behind a stalled output, then reset.
        @(negedge i_clkp);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_d     = vd[k];
            i_c     = vc[k];
            @(negedge i_clkp);
        end
        i_valid = 1'b0;
        wcnt = 0;
        while (!o_valid && wcnt < 20) begin
            @(negedge i_clkp);
            wcnt++;
        end
        chk("mr_pre_valid", 64'(o_valid), 64'(1));
        chk("mr_pre_sum",   64'(o_sum),   64'(ewrp[0]));
        i_rst = 1'b1;
        #1;
        chk("mr_valid", 64'(o_valid), 64'(0));
        chk("mr_sum",   64'(o_sum),   64'(0));
        chk("mr_ovf",   64'(o_ovf),   64'(0));
        @(negedge i_clkp);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        #1;
        chk("mr_ready", 64'(o_ready), 64'(1));
        stale = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clkp);
            if (o_valid) stale = 1'b1;
        end
        chk("mr_no_stale", 64'(stale), 64'(0));
        run_one("post_rst", 32'h0000_0005, 32'h0000_0002, 32'h0000_0009, 32'h0000_0009, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_decoder.md
CSA_DECODER -- requirements
Module: csa_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width of each redundant operand and of the result.
REQ-002 The block SHALL have parameter SEGS, default 4, meaning number of carry-propagate segments (pipeline stages); WIDTH % SEGS == 0 is required.
REQ-003 The block SHALL have port i_clkp, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: input pair present.
REQ-006 The block SHALL have port o_ready, output, 1 bit: block can accept an input this cycle.
REQ-007 The block SHALL have port i_d, input, WIDTH bits: signed sum vector, bit i weight 2^i.
REQ-008 The block SHALL have port i_c, input, WIDTH bits: signed carry vector, bit i weight 2^(i+1).
REQ-009 The block SHALL have port o_valid, output, 1 bit: result present.
REQ-010 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port o_sum, output, WIDTH bits: resolved two's-complement result.
REQ-012 The block SHALL have port o_ovf, output, 1 bit: true value exceeded the signed WIDTH range.

Function
REQ-013 Transfer rules: input accepted when i_valid & o_ready; output consumed when o_valid & i_ready.
REQ-014 True value V = signed(i_d) + 2*signed(i_c), computed in WIDTH+2 bits.
REQ-015 Segment k (0..SEGS-1) resolves bits [k*W/S +: W/S] in stage k, using the carry registered from stage k-1; stage 0 carry-in is 0.
REQ-016 Unresolved upper bits and each stage's carry travel with their token through per-stage registers.
REQ-017 Latency from acceptance to o_valid is SEGS cycles when no stall occurs.
REQ-018 Throughput: one result per cycle while i_ready is held high.
REQ-019 Each stage holds a valid bit and advances when the next stage is empty or advancing, so bubbles collapse.
REQ-020 o_ready = ~stage0_valid | stage0_advances; the block SHALL never drop or duplicate a token.
REQ-021 Results leave in acceptance order.
REQ-022 o_sum, o_ovf and o_valid SHALL hold stable while o_valid & ~i_ready.
REQ-023 o_ovf = 1 iff V < -2^(WIDTH-1) or V > 2^(WIDTH-1)-1.
REQ-024 Without saturation, o_sum = V mod 2^WIDTH.

Reset
REQ-025 On i_rst, all stage valid bits, o_valid, o_sum and o_ovf SHALL clear to 0 immediately; o_ready SHALL be 1 once reset deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight tokens; no stale result may appear afterwards.

Configuration
REQ-027 Macro CSA_DECODER_SAT_EN: when defined, an extra output register stage SHALL clamp o_sum to 2^(WIDTH-1)-1 or -2^(WIDTH-1) when o_ovf = 1, and latency SHALL become SEGS+1.
REQ-028 Without CSA_DECODER_SAT_EN, o_sum SHALL wrap per REQ-024 and latency SHALL be SEGS; o_ovf behaves identically in both builds.

Structure
REQ-029 Shared package csa_pkg SHALL hold the default WIDTH/SEGS constants, the segment-width constant, and the signed min/max constant functions.
REQ-030 Sub-module csa_seg_stage SHALL hold one segment: adder, carry register, valid/advance logic. The top instantiates SEGS copies.

Verification (WIDTH=32, SEGS=4)
REQ-031 Basic: d=0x000000FF, c=0x00000001 -> o_sum=0x00000101, o_ovf=0, o_valid 4 cycles after accept.
REQ-032 Full carry ripple: d=0xFFFFFFFF, c=0x00000001 -> o_sum=0x00000001, o_ovf=0.
REQ-033 Overflow: d=0x7FFFFFFF, c=0x00000001 -> o_sum=0x80000001, o_ovf=1. With CSA_DECODER_SAT_EN: o_sum=0x7FFFFFFF, o_ovf=1, latency 5.
REQ-034 Backpressure: 6 back-to-back inputs with i_ready low for cycles 3-7 -> o_ready drops when all stages are full, all 6 results emerge in order, outputs stable while stalled.
REQ-035 Reset mid-flight: assert i_rst with 3 tokens in flight -> o_valid=0 at once, and no result appears after release until a new input is accepted.
